// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : key_event_fifo
// Purpose  : Converts the 16-bit debounced keypad level bitmap into press /
//            release event words, buffers them in a FIFO and exposes the
//            queue through an APB slave window with a level interrupt.
// Ports    : clk, rst_n (async, active-low)
//            key_state[15:0]        key levels, 1 = pressed
//            PSEL/PENABLE/PWRITE/PADDR[3:0]/PWDATA[31:0]  APB request
//            PRDATA[31:0]           combinational read data
//            PREADY                 always 1
//            key_irq                IRQ_EN & FIFO non-empty
// Registers: 0x0 DATA (read pops), 0x4 STATUS, 0x8 CTRL
// Options  : KEY_EVT_TIMESTAMP_EN - store a 16-bit cycle stamp per entry,
//            returned in DATA[23:8]
// Revision : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] key_state,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        key_irq
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef KEY_EVT_TIMESTAMP_EN
  localparam int c_EW = 21;
`else
  localparam int c_EW = 5;
`endif
  localparam logic [CW-1:0]   c_CNT_ONE = 1;
  localparam logic [c_AW-1:0] c_PTR_ONE = 1;

  logic [15:0]     r_prev;
  logic [15:0]     r_pend_press;
  logic [15:0]     r_pend_rel;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_irq_en;
  logic            r_rel_en;
  logic [c_EW-1:0] r_mem [DEPTH];

  logic [15:0] w_press;
  logic [15:0] w_rel;
  logic        w_sel_valid;
  logic        w_sel_is_press;
  logic [3:0]  w_sel_idx;
  logic [15:0] w_clr_press;
  logic [15:0] w_clr_rel;
  logic [c_EW-1:0] w_entry;
  logic [c_EW-1:0] w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_flush;
  logic [31:0] w_data;
  logic [31:0] w_status;
  logic [31:0] w_ctrl;

  assign w_press  = key_state & ~r_prev;
  assign w_rel    = ~key_state & r_prev;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_rd_acc = PSEL & PENABLE & ~PWRITE;
  assign w_wr_acc = PSEL & PENABLE & PWRITE;
  assign w_pop    = w_rd_acc & (PADDR == 4'h0) & ~w_empty;
  assign w_flush  = w_wr_acc & (PADDR == 4'h8) & PWDATA[2];
  // A flush discards everything, including the event selected this cycle.
  assign w_push    = w_sel_valid & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_sel_valid & ~w_flush & w_full & ~w_pop;

  // Lowest-indexed pending press wins; releases only when no press pending.
  always_comb begin
    w_sel_valid    = 1'b0;
    w_sel_is_press = 1'b0;
    w_sel_idx      = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_pend_rel[i]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = 4'(i);
      end
    end
    for (int i = 15; i >= 0; i--) begin
      if (r_pend_press[i]) begin
        w_sel_valid    = 1'b1;
        w_sel_is_press = 1'b1;
        w_sel_idx      = 4'(i);
      end
    end
  end

  assign w_clr_press = (w_sel_valid &  w_sel_is_press) ? (16'd1 << w_sel_idx) : 16'd0;
  assign w_clr_rel   = (w_sel_valid & ~w_sel_is_press) ? (16'd1 << w_sel_idx) : 16'd0;

`ifdef KEY_EVT_TIMESTAMP_EN
  logic [15:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= 16'd0;
    else        r_ts <= r_ts + 16'd1;
  end

  assign w_entry = {r_ts, w_sel_is_press, w_sel_idx};
`else
  assign w_entry = {w_sel_is_press, w_sel_idx};
`endif

  // Storage has no reset; only entries behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= 16'd0;
      r_pend_press <= 16'd0;
      r_pend_rel   <= 16'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_irq_en     <= 1'b0;
      r_rel_en     <= 1'b0;
    end else begin
      r_prev <= key_state;

      if (w_flush) begin
        r_pend_press <= 16'd0;
        r_pend_rel   <= 16'd0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
      end else begin
        // New edges set after the served bit clears, so a re-press of the
        // key being served is not lost.
        r_pend_press <= (r_pend_press & ~w_clr_press) | w_press;
        r_pend_rel   <= (r_pend_rel & ~w_clr_rel) | (r_rel_en ? w_rel : 16'd0);
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end

      // Overflow set takes priority over a software clear in the same cycle.
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr_acc && (PADDR == 4'h4) && PWDATA[8])
        r_ovf <= 1'b0;

      if (w_wr_acc && (PADDR == 4'h8)) begin
        r_irq_en <= PWDATA[0];
        r_rel_en <= PWDATA[1];
      end
    end
  end

  always_comb begin
    w_data   = 32'd0;
    w_status = 32'd0;
    w_ctrl   = 32'd0;
    w_data[31] = ~w_empty;
    if (!w_empty) begin
      w_data[4:0] = w_head[4:0];
`ifdef KEY_EVT_TIMESTAMP_EN
      w_data[23:8] = w_head[20:5];
`endif
    end
    w_status[CW-1:0] = r_count;
    w_status[8]      = r_ovf;
    w_status[9]      = w_full;
    w_ctrl[1:0]      = {r_rel_en, r_irq_en};
    case (PADDR)
      4'h0:    PRDATA = w_data;
      4'h4:    PRDATA = w_status;
      4'h8:    PRDATA = w_ctrl;
      default: PRDATA = 32'd0;
    endcase
  end

  assign PREADY  = 1'b1;
  assign key_irq = r_irq_en & ~w_empty;

  logic w_unused;
  assign w_unused = ^{PWDATA[31:9], PWDATA[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_key_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_fifo
// Purpose  : Self-checking bench for key_event_fifo (DEPTH = 8). Expected
//            event words are queued as key stimulus is driven and compared
//            as DATA is popped over APB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] key_state;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        key_irq;

  int n_vec;
  int n_err;
  logic [4:0] sb [$];

  key_event_fifo #(.DEPTH(8), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_state (key_state),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .key_irq   (key_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = 32'd0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    d = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PADDR = 4'h0;
  endtask

  // Timestamp field is excluded here; it is checked separately.
  function automatic logic [31:0] data_word(input logic [31:0] raw);
    return raw & 32'hFF0000FF;
  endfunction

  task automatic pop_check(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    apb_read(4'h0, d);
    if (sb.size() > 0) exp = {1'b1, 26'd0, sb.pop_front()};
    else               exp = 32'd0;
    check(tag, data_word(d), exp);
  endtask

  task automatic status_check(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(4'h4, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; key_state = 16'd0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = 32'd0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(1);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pready", {31'd0, PREADY}, 32'd1);
    check("rst_irq", {31'd0, key_irq}, 32'd0);

    // Single press of key 5 with IRQ enabled
    apb_write(4'h8, 32'h1);
    @(negedge clk);
    key_state = 16'h0020; sb.push_back(5'h15);
    @(negedge clk);
    check("irq_after_e0", {31'd0, key_irq}, 32'd0);
    @(negedge clk);
    check("irq_after_e1", {31'd0, key_irq}, 32'd1);
    status_check("k5_count", 32'h1);
    pop_check("k5_data");
    status_check("k5_count_after", 32'h0);
    check("k5_irq_after", {31'd0, key_irq}, 32'd0);
    key_state = 16'h0000;
    wait_cyc(3);

    // Three simultaneous presses serialize lowest index first
    key_state = 16'h8101;
    sb.push_back(5'h10); sb.push_back(5'h18); sb.push_back(5'h1F);
    wait_cyc(6);
    pop_check("multi_0");
    pop_check("multi_8");
    pop_check("multi_15");
    pop_check("multi_empty");
    key_state = 16'h0000;
    wait_cyc(3);

    // Release events gated by REL_EN
    key_state = 16'h0004; sb.push_back(5'h12);
    wait_cyc(3);
    key_state = 16'h0000;
    wait_cyc(3);
    status_check("relen0_count", 32'h1);
    pop_check("relen0_press");
    apb_write(4'h8, 32'h3);
    key_state = 16'h0004; sb.push_back(5'h12);
    wait_cyc(3);
    key_state = 16'h0000; sb.push_back(5'h02);
    wait_cyc(3);
    pop_check("relen1_press");
    pop_check("relen1_release");

    // Nine presses into an 8-deep FIFO: last one dropped, OVF set
    apb_write(4'h8, 32'h1);
    key_state = 16'h01FF;
    for (int i = 0; i < 8; i++) sb.push_back(5'h10 | 5'(i));
    wait_cyc(12);
    status_check("ovf_status", 32'h308);
    check("ovf_irq", {31'd0, key_irq}, 32'd1);
    apb_write(4'h4, 32'h100);
    status_check("ovf_cleared", 32'h208);

    // Full FIFO: pop and push land on the same edge
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    key_state = key_state | 16'h0200;
    @(negedge clk);
    PENABLE = 1'b1;
    d = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    check("full_pop_data", data_word(d), {1'b1, 26'd0, sb.pop_front()});
    sb.push_back(5'h19);
    status_check("full_poppush_status", 32'h208);
    apb_write(4'h8, 32'h5);
    status_check("flush_status", 32'h0);
    check("flush_irq", {31'd0, key_irq}, 32'd0);
    pop_check_flushed();

    // Reset mid-operation; held keys re-generate press events afterwards
    key_state = 16'h8001;
    wait_cyc(4);
    status_check("pre_reset_count", 32'h1);
    check("pre_reset_irq", {31'd0, key_irq}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("in_reset_irq", {31'd0, key_irq}, 32'd0);
    PADDR = 4'h4;
    #1;
    check("in_reset_status", PRDATA, 32'd0);
    PADDR = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    sb.push_back(5'h10); sb.push_back(5'h1F);
    wait_cyc(4);
    pop_check("held_key0");
    pop_check("held_key15");
    pop_check("held_empty");

`ifdef KEY_EVT_TIMESTAMP_EN
    begin
      logic [31:0] d1;
      logic [31:0] d2;
      key_state = 16'h0000;
      wait_cyc(3);
      key_state = 16'h0008;
      wait_cyc(100);
      key_state = 16'h0018;
      wait_cyc(4);
      apb_read(4'h0, d1);
      apb_read(4'h0, d2);
      check("ts_first", data_word(d1), 32'h80000013);
      check("ts_second", data_word(d2), 32'h80000014);
      check("ts_delta", {16'd0, d2[23:8] - d1[23:8]}, 32'd100);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // After a flush the queued expectations are void and DATA must read empty.
  task automatic pop_check_flushed();
    logic [31:0] d;
    sb.delete();
    apb_read(4'h0, d);
    check("flush_data", d, 32'd0);
  endtask

endmodule
`default_nettype wire

// File: doc/key_event_fifo.md
# key_event_fifo

Keyboard event queue sitting directly downstream of the APB keypad block in the BuzzerMusicSoC. It consumes the 16-bit debounced key-level bitmap, converts press/release edges into serialized event words, and buffers them in a FIFO. Software pops events through an APB slave window, with an interrupt raised while events are pending. The block replaces polling of raw key levels for the buzzer note player.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CW, 4, count width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_state  in  16  debounced key levels from the keypad block, 1 = pressed, synchronous to clk.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  4  byte address: 0x0 DATA, 0x4 STATUS, 0x8 CTRL.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data, combinational.
- PREADY  out  1  tied 1, no wait states.
- key_irq  out  1  level interrupt.

## Operation
- Edge detect: prev register (reset 0) samples key_state every edge. Pressed keys are key_state & ~prev; released keys are ~key_state & prev. Each pressed key sets its pend_press bit. Each released key sets its pend_release bit, but only when CTRL.REL_EN = 1.
- Serializer: each cycle selects one pending event. The lowest-indexed pend_press bit wins. If none is set, the lowest-indexed pend_release bit wins. The selected pending bit clears. Event word: [3:0] key index, [4] 1 = press / 0 = release.
- Full FIFO at push time with no same-cycle pop: the event is dropped, STATUS.OVF (sticky) is set, and the pending bit still clears.
- Same-cycle pop and push: both are performed, including when the FIFO is full.
- Pop: an APB access phase (PSEL & PENABLE & ~PWRITE) at 0x0 pops when the FIFO is non-empty. A read while empty does not pop.
- DATA read value: [31] = non-empty, [4:0] = head entry, other bits 0. Bits [4:0] read 0 when empty.
- STATUS read value: [6:0] = count, zero-extended; [8] = OVF; [9] = full.
- Writing STATUS with [8] = 1 clears OVF. If an overflow occurs in the same cycle, set wins.
- CTRL: [0] IRQ_EN, [1] REL_EN. Both reset to 0 and are read/write.
- CTRL[2] = 1 on a write flushes the FIFO and all pending bits. This bit is self-clearing and reads 0.
- Writes to DATA are ignored. Unmapped addresses read 0 and writes to them are ignored.
- key_irq = IRQ_EN & (count != 0).

## Timing
- Reset values: PRDATA = 0 (DATA selected), PREADY = 1, key_irq = 0. prev, pending, FIFO pointers, count, OVF and CTRL all reset to 0.
- Event latency, single event: key_state changes before edge E0. Pending is set at E0. The event is written at E1, and count/key_irq reflect it after E1.
- N simultaneous edges: events enter the FIFO at E1..EN in priority order.
- A press and release of the same key both pending: the press is emitted first.
- Pop: the head advances at the edge ending the access phase. PRDATA is valid during the access phase.
- Clearing REL_EN does not clear already-pending release bits.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-operation clears everything asynchronously. The first edge after release re-samples key_state against prev = 0, so keys held through reset generate press events.

## Configuration
- KEY_EVT_TIMESTAMP_EN: when defined, a 16-bit free-running cycle counter (reset 0, wraps) is captured into each FIFO entry at push. DATA[23:8] returns the head's timestamp, and FIFO entry width is 21 bits.
- When undefined, the counter is not built, entries are 5 bits, and DATA[23:8] reads 0.

## Test plan
- Key 5 pressed alone, IRQ_EN = 1 → count = 1 and key_irq = 1 two edges after the change. DATA read = 0x80000015. Count then returns to 0 and key_irq drops.
- key_state 0x0000 → 0x8101 in one cycle → DATA reads 0x80000010, 0x80000018, 0x8000001F in order, then 0x00000000.
- REL_EN = 0: press then release key 2 → one event only. REL_EN = 1: release queues 0x80000002.
- DEPTH = 8: press 9 keys with no reads → count = 8, STATUS = 0x308. Write STATUS 0x100 → OVF clears.
- FIFO full, with a pop on the same cycle a new event is pushed → count stays 8, OVF stays 0. CTRL write 0x4 → count = 0, key_irq = 0.
- With KEY_EVT_TIMESTAMP_EN: two presses 100 cycles apart → DATA[23:8] timestamps differ by 100.
